// File: rtl/gen_con.sv
// gen_con: general controller for a 16-bit signed keypad calculator.
//
// Builds two signed operands from decimal key presses, applies
// add/subtract/multiply when the equal key is pressed, and drives a 16-bit
// sign-magnitude display word. Bit 15 is the sign and bits 14:0 are the
// magnitude. Magnitudes are limited to 32767.
//
// Ports:
//   clk              system clock, rising edge
//   nRST             synchronous active-low reset
//   keypad_input     digit value 0-9 (10-15 ignored)
//   read_input       digit strobe, keypad_input valid while high
//   operator_input   001 negate, 010 add, 011 subtract, 100 multiply
//   equal_input      equal key (level, acted on at its rising edge)
//   complete         result valid flag, held until new entry
//   display_output   sign-magnitude value currently shown
//   tb_current_state current FSM state encoding
module gen_con (
  input  logic        clk,
  input  logic        nRST,
  input  logic [3:0]  keypad_input,
  input  logic        read_input,
  input  logic [2:0]  operator_input,
  input  logic        equal_input,
  output logic        complete,
  output logic [15:0] display_output,
  output logic [2:0]  tb_current_state
);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    DIGIT_A = 3'd1,
    OP_SEL  = 3'd2,
    ENTER_B = 3'd3,
    DIGIT_B = 3'd4,
    COMPUTE = 3'd5,
    DONE    = 3'd6
  } state_t;

  localparam logic [2:0] OP_NEG = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  state_t state;
  state_t next_state;

  logic        sign_a;
  logic        sign_b;
  logic [14:0] mag_a;
  logic [14:0] mag_b;
  logic [2:0]  op_reg;
  logic [2:0]  op_prev;
  logic        eq_prev;

  logic [29:0] product;
  logic [29:0] mcand;
  logic [14:0] mplier;
  logic [3:0]  mul_count;

  logic        op_edge;
  logic        eq_edge;
  logic        digit_ok;
  logic        is_negate;
  logic        is_arith;
  logic        compute_finish;

  logic        do_digit;
  logic        do_negate;
  logic        do_op;
  logic        do_equal;

  logic        cur_sign;
  logic [14:0] cur_mag;
  logic [19:0] digit_sum;
  logic [14:0] digit_mag;

  logic signed [16:0] a_tc;
  logic signed [16:0] b_tc;
  logic signed [16:0] sum_raw;
  logic signed [16:0] sum_sat;
  logic        [16:0] sum_neg;
  logic        [15:0] addsub_word;
  logic        [14:0] mul_mag;
  logic               mul_sign;
  logic        [15:0] result_word;

  // Operator keys act only when leaving the all-zero code; equal only on 0->1.
  assign op_edge   = (op_prev == 3'b000) && (operator_input != 3'b000);
  assign eq_edge   = equal_input && !eq_prev;
  assign digit_ok  = read_input && (keypad_input <= 4'd9);
  assign is_negate = op_edge && (operator_input == OP_NEG);
  assign is_arith  = op_edge && ((operator_input == OP_ADD) ||
                                 (operator_input == OP_SUB) ||
                                 (operator_input == OP_MUL));

  // Multiply needs 15 shift-add steps before the result is final.
  assign compute_finish = (state == COMPUTE) &&
                          ((op_reg != OP_MUL) || (mul_count == 4'd15));

  // The operand being edited depends on which entry phase we are in.
  assign cur_sign  = (state == ENTER_B) ? sign_b : sign_a;
  assign cur_mag   = (state == ENTER_B) ? mag_b : mag_a;
  assign digit_sum = ({5'd0, cur_mag} * 20'd10) + {16'd0, keypad_input};
  // A digit that would overflow the magnitude is dropped.
  assign digit_mag = (digit_sum <= 20'd32767) ? digit_sum[14:0] : cur_mag;

  // Add/subtract is done in 17-bit two's complement, which cannot overflow
  // for two 15-bit magnitudes, then clamped to the displayable range.
  assign a_tc    = sign_a ? -$signed({2'b00, mag_a}) : $signed({2'b00, mag_a});
  assign b_tc    = sign_b ? -$signed({2'b00, mag_b}) : $signed({2'b00, mag_b});
  assign sum_raw = (op_reg == OP_SUB) ? (a_tc - b_tc) : (a_tc + b_tc);

  always_comb begin
    sum_sat = sum_raw;
    if (sum_raw > 17'sd32767) begin
      sum_sat = 17'sd32767;
    end else if (sum_raw < -17'sd32767) begin
      sum_sat = -17'sd32767;
    end
  end

  assign sum_neg     = -sum_sat;
  assign addsub_word = sum_sat[16] ? {1'b1, sum_neg[14:0]} : {1'b0, sum_sat[14:0]};

  // A zero product must never show a negative sign.
  assign mul_mag     = (product > 30'd32767) ? 15'h7FFF : product[14:0];
  assign mul_sign    = (sign_a ^ sign_b) && (mul_mag != 15'd0);
  assign result_word = (op_reg == OP_MUL) ? {mul_sign, mul_mag} : addsub_word;

  // State register.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state <= ENTER_A;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and action strobes. A digit strobe takes priority
  // over any operator or equal edge arriving in the same cycle.
  always_comb begin
    next_state = state;
    do_digit   = 1'b0;
    do_negate  = 1'b0;
    do_op      = 1'b0;
    do_equal   = 1'b0;
    case (state)
      ENTER_A: begin
        if (digit_ok) begin
          do_digit   = 1'b1;
          next_state = DIGIT_A;
        end else if (is_negate) begin
          do_negate = 1'b1;
        end else if (is_arith) begin
          do_op      = 1'b1;
          next_state = OP_SEL;
        end
      end
      DIGIT_A: begin
        if (!read_input) next_state = ENTER_A;
      end
      OP_SEL: begin
        next_state = ENTER_B;
      end
      ENTER_B: begin
        if (digit_ok) begin
          do_digit   = 1'b1;
          next_state = DIGIT_B;
        end else if (eq_edge) begin
          do_equal   = 1'b1;
          next_state = COMPUTE;
        end else if (is_negate) begin
          do_negate = 1'b1;
        end else if (is_arith) begin
          do_op = 1'b1;
        end
      end
      DIGIT_B: begin
        if (!read_input) next_state = ENTER_B;
      end
      COMPUTE: begin
        if (compute_finish) next_state = DONE;
      end
      DONE: begin
        next_state = ENTER_A;
      end
      default: begin
        next_state = ENTER_A;
      end
    endcase
  end

  // Operand, operator, multiplier and display registers.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      mag_a          <= 15'd0;
      mag_b          <= 15'd0;
      op_reg         <= 3'b000;
      op_prev        <= 3'b000;
      eq_prev        <= 1'b0;
      product        <= 30'd0;
      mcand          <= 30'd0;
      mplier         <= 15'd0;
      mul_count      <= 4'd0;
      display_output <= 16'd0;
      complete       <= 1'b0;
    end else begin
      op_prev <= operator_input;
      eq_prev <= equal_input;

      if (do_digit) begin
        if (state == ENTER_B) mag_b <= digit_mag;
        else                  mag_a <= digit_mag;
        display_output <= {cur_sign && (digit_mag != 15'd0), digit_mag};
        complete       <= 1'b0;
      end

      if (do_negate) begin
        if (state == ENTER_B) sign_b <= ~sign_b;
        else                  sign_a <= ~sign_a;
        display_output <= {~cur_sign && (cur_mag != 15'd0), cur_mag};
        complete       <= 1'b0;
      end

      if (do_op) begin
        op_reg <= operator_input;
      end

      if (state == OP_SEL) begin
        sign_b         <= 1'b0;
        mag_b          <= 15'd0;
        display_output <= 16'd0;
      end

      if (do_equal) begin
        product   <= 30'd0;
        mcand     <= {15'd0, mag_a};
        mplier    <= mag_b;
        mul_count <= 4'd0;
      end

      if ((state == COMPUTE) && (op_reg == OP_MUL) && (mul_count != 4'd15)) begin
        product   <= product + (mplier[0] ? mcand : 30'd0);
        mcand     <= mcand << 1;
        mplier    <= mplier >> 1;
        mul_count <= mul_count + 4'd1;
      end

      if (compute_finish) begin
        display_output <= result_word;
        complete       <= 1'b1;
      end

      if (state == DONE) begin
        sign_a <= 1'b0;
        sign_b <= 1'b0;
        mag_a  <= 15'd0;
        mag_b  <= 15'd0;
      end
    end
  end

  assign tb_current_state = state;

endmodule

// File: tb/tb_gen_con.sv
// tb_gen_con: self-checking bench for gen_con.
// Key presses update a behavioural calculator model; each equal press
// pushes the expected result and latency into a queue that a separate
// monitor pops whenever the DUT sits in its DONE state.
module tb_gen_con;

  logic        clk;
  logic        nRST;
  logic [3:0]  keypad_input;
  logic        read_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        complete;
  logic [15:0] display_output;
  logic [2:0]  tb_current_state;

  localparam int K_DIGIT = 0;
  localparam int K_OP    = 1;
  localparam int K_EQ    = 2;
  localparam int K_DIGOP = 3;

  typedef struct {
    logic [15:0] disp;
    int          lat;
    int          start;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks;
  int failures;
  int cyc;

  bit   m_sa;
  bit   m_sb;
  int   m_ma;
  int   m_mb;
  bit   m_inb;
  int   m_op;
  logic [15:0] m_disp;
  bit   m_comp;
  bit   hold_eq;
  int   nd;
  int   key;

  gen_con dut (
    .clk              (clk),
    .nRST             (nRST),
    .keypad_input     (keypad_input),
    .read_input       (read_input),
    .operator_input   (operator_input),
    .equal_input      (equal_input),
    .complete         (complete),
    .display_output   (display_output),
    .tb_current_state (tb_current_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  function automatic logic [15:0] to_sm(input int v);
    logic [15:0] r;
    if (v < 0) r = {1'b1, 15'(-v)};
    else       r = {1'b0, 15'(v)};
    return r;
  endfunction

  function automatic int clamp(input int v);
    if (v > 32767)  return 32767;
    if (v < -32767) return -32767;
    return v;
  endfunction

  function automatic int sval(input bit s, input int m);
    return s ? -m : m;
  endfunction

  task automatic cmp(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Compare the visible DUT outputs with the model between key presses.
  task automatic checkOutput(input string tag);
    cmp({tag, "_state"}, int'(tb_current_state), m_inb ? 3 : 0);
    cmp({tag, "_display"}, int'(display_output), int'(m_disp));
    cmp({tag, "_complete"}, int'(complete), int'(m_comp));
  endtask

  task automatic model_reset();
    m_sa = 0; m_sb = 0; m_ma = 0; m_mb = 0;
    m_inb = 0; m_op = 0; m_disp = 16'd0; m_comp = 0;
  endtask

  task automatic model_digit(input int k);
    int nm;
    if (k > 9) return;
    if (m_inb) begin
      nm = m_mb * 10 + k;
      if (nm <= 32767) m_mb = nm;
      m_disp = to_sm(sval(m_sb, m_mb));
    end else begin
      nm = m_ma * 10 + k;
      if (nm <= 32767) m_ma = nm;
      m_disp = to_sm(sval(m_sa, m_ma));
    end
    m_comp = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRST = 1'b0;
    keypad_input = 4'd0; read_input = 1'b0;
    operator_input = 3'b000; equal_input = 1'b0;
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  // One key action: drives the pins, waits for the DUT to settle back
  // into an entry state, updates the model and checks the outputs.
  task automatic applyStimulus(input int kind, input int arg);
    exp_t e;
    int a;
    int b;
    int r;
    case (kind)
      K_DIGIT, K_DIGOP: begin
        @(negedge clk);
        keypad_input = arg[3:0];
        read_input   = 1'b1;
        if (kind == K_DIGOP) operator_input = 3'b010;
        @(negedge clk);
        read_input     = 1'b0;
        operator_input = 3'b000;
        @(negedge clk);
        model_digit(arg);
      end
      K_OP: begin
        @(negedge clk);
        operator_input = arg[2:0];
        @(negedge clk);
        operator_input = 3'b000;
        @(negedge clk);
        if (arg == 1) begin
          if (m_inb) begin
            m_sb = !m_sb;
            m_disp = to_sm(sval(m_sb, m_mb));
          end else begin
            m_sa = !m_sa;
            m_disp = to_sm(sval(m_sa, m_ma));
          end
          m_comp = 0;
        end else if (!m_inb) begin
          m_op = arg; m_inb = 1; m_sb = 0; m_mb = 0; m_disp = 16'd0;
        end else begin
          m_op = arg;
        end
      end
      default: begin
        @(negedge clk);
        equal_input = 1'b1;
        if (m_inb) begin
          a = sval(m_sa, m_ma);
          b = sval(m_sb, m_mb);
          if (m_op == 2)      r = a + b;
          else if (m_op == 3) r = a - b;
          else                r = a * b;
          r = clamp(r);
          e.disp  = to_sm(r);
          e.lat   = (m_op == 4) ? 17 : 2;
          e.start = cyc;
          exp_q.push_back(e);
          m_disp = e.disp; m_comp = 1;
          m_sa = 0; m_sb = 0; m_ma = 0; m_mb = 0; m_inb = 0;
        end
        @(negedge clk);
        if (!hold_eq) equal_input = 1'b0;
        repeat (20) @(negedge clk);
      end
    endcase
    checkOutput($sformatf("key%0d_%0d", kind, arg));
  endtask

  // Monitor: the single DONE cycle is where the DUT presents a result.
  always @(negedge clk) begin
    if (nRST && (tb_current_state == 3'd6)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done actual=%0h required=none", display_output);
      end else begin
        mon_e = exp_q.pop_front();
        cmp("result_display", int'(display_output), int'(mon_e.disp));
        cmp("result_complete", int'(complete), 1);
        cmp("result_latency", cyc - mon_e.start, mon_e.lat);
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0; failures = 0; hold_eq = 0;
    nRST = 1'b0; keypad_input = 4'd0; read_input = 1'b0;
    operator_input = 3'b000; equal_input = 1'b0;
    model_reset();
    do_reset();
    checkOutput("reset");

    // -25 + -15 = -40
    applyStimulus(K_OP, 1); applyStimulus(K_DIGIT, 2); applyStimulus(K_DIGIT, 5);
    applyStimulus(K_OP, 2); applyStimulus(K_OP, 1);
    applyStimulus(K_DIGIT, 1); applyStimulus(K_DIGIT, 5);
    applyStimulus(K_EQ, 0);

    // 1000 + 2345 = 3345
    applyStimulus(K_DIGIT, 1); applyStimulus(K_DIGIT, 0); applyStimulus(K_DIGIT, 0);
    applyStimulus(K_DIGIT, 0); applyStimulus(K_OP, 2);
    applyStimulus(K_DIGIT, 2); applyStimulus(K_DIGIT, 3); applyStimulus(K_DIGIT, 4);
    applyStimulus(K_DIGIT, 5); applyStimulus(K_EQ, 0);

    // -3 - -5 = 2, then 99 - 0 = 99
    applyStimulus(K_OP, 1); applyStimulus(K_DIGIT, 3); applyStimulus(K_OP, 3);
    applyStimulus(K_OP, 1); applyStimulus(K_DIGIT, 5); applyStimulus(K_EQ, 0);
    applyStimulus(K_DIGIT, 9); applyStimulus(K_DIGIT, 9); applyStimulus(K_OP, 3);
    applyStimulus(K_EQ, 0);

    // -3 * -6 = 18, then 128 * 256 saturates
    applyStimulus(K_OP, 1); applyStimulus(K_DIGIT, 3); applyStimulus(K_OP, 4);
    applyStimulus(K_OP, 1); applyStimulus(K_DIGIT, 6); applyStimulus(K_EQ, 0);
    applyStimulus(K_DIGIT, 1); applyStimulus(K_DIGIT, 2); applyStimulus(K_DIGIT, 8);
    applyStimulus(K_OP, 4);
    applyStimulus(K_DIGIT, 2); applyStimulus(K_DIGIT, 5); applyStimulus(K_DIGIT, 6);
    applyStimulus(K_EQ, 0);

    // Zero results carry a positive sign
    applyStimulus(K_DIGIT, 0); applyStimulus(K_OP, 4);
    applyStimulus(K_DIGIT, 1); applyStimulus(K_DIGIT, 0); applyStimulus(K_DIGIT, 0);
    applyStimulus(K_EQ, 0);
    applyStimulus(K_OP, 1); applyStimulus(K_DIGIT, 1); applyStimulus(K_OP, 2);
    applyStimulus(K_DIGIT, 1); applyStimulus(K_EQ, 0);

    // Overflowing digit dropped: 40000 -> 4000
    applyStimulus(K_DIGIT, 4); applyStimulus(K_DIGIT, 0); applyStimulus(K_DIGIT, 0);
    applyStimulus(K_DIGIT, 0); applyStimulus(K_DIGIT, 0);
    applyStimulus(K_OP, 2); applyStimulus(K_EQ, 0);

    // Digit and operator edge together: digit wins
    applyStimulus(K_DIGOP, 7); applyStimulus(K_OP, 3); applyStimulus(K_DIGIT, 12);
    applyStimulus(K_DIGIT, 9); applyStimulus(K_EQ, 0);

    // Equal held across DONE must not start another computation
    applyStimulus(K_DIGIT, 6); applyStimulus(K_OP, 2); applyStimulus(K_DIGIT, 1);
    hold_eq = 1;
    applyStimulus(K_EQ, 0);
    applyStimulus(K_DIGIT, 2); applyStimulus(K_OP, 2); applyStimulus(K_DIGIT, 3);
    repeat (4) @(negedge clk);
    checkOutput("held_equal");
    hold_eq = 0;
    equal_input = 1'b0;
    @(negedge clk);
    applyStimulus(K_EQ, 0);

    // Reset in the middle of a multiply aborts it
    applyStimulus(K_DIGIT, 1); applyStimulus(K_DIGIT, 2); applyStimulus(K_OP, 4);
    applyStimulus(K_DIGIT, 3);
    @(negedge clk);
    equal_input = 1'b1;
    repeat (5) @(negedge clk);
    cmp("pre_reset_state", int'(tb_current_state), 5);
    nRST = 1'b0;
    @(negedge clk);
    model_reset();
    checkOutput("reset_in_compute");
    nRST = 1'b1;
    equal_input = 1'b0;
    @(negedge clk);

    // Randomized operand/operator sequences
    for (int s = 0; s < 14; s++) begin
      if ($urandom_range(0, 3) == 0) applyStimulus(K_OP, 1);
      nd = int'($urandom_range(0, 5));
      for (int i = 0; i < nd; i++) begin
        key = ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 9));
        applyStimulus(K_DIGIT, key);
      end
      applyStimulus(K_OP, int'($urandom_range(2, 4)));
      if ($urandom_range(0, 3) == 0) applyStimulus(K_OP, 1);
      nd = int'($urandom_range(0, 5));
      for (int i = 0; i < nd; i++) begin
        applyStimulus(K_DIGIT, int'($urandom_range(0, 9)));
      end
      if ($urandom_range(0, 4) == 0) applyStimulus(K_OP, int'($urandom_range(2, 4)));
      applyStimulus(K_EQ, 0);
    end

    cmp("pending_results", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gen_con.md
Name: gen_con

Overview:
- General controller for the 16-bit signed calculator.
- Accepts decimal digit key presses, a sign-toggle key, an operator key (add/subtract/multiply) and an equal key.
- Builds two signed operands, computes the result and drives a 16-bit sign-magnitude display word.
- Sits between the keypad/button decoders and the display driver; exposes its FSM state for bench synchronisation.

Parameters:
- None. Data width is fixed at 16 bits: bit 15 is the sign, bits 14:0 are the magnitude.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- nRST  in  1  synchronous active-low reset, sampled on rising clk edge.
- keypad_input  in  4  digit value 0-9; codes 10-15 are ignored.
- read_input  in  1  digit strobe; keypad_input is valid while high.
- operator_input  in  3  001 negate, 010 add, 011 subtract, 100 multiply; 000 and other codes are none.
- equal_input  in  1  equal key, level.
- complete  out  1  result valid flag.
- display_output  out  16  sign-magnitude value shown.
- tb_current_state  out  3  current FSM state encoding (state_t).

Behaviour:
- Interface (already decided): one clock, clk; reset nRST is synchronous and active-low.
- Reset: state=ENTER_A(0); A and B cleared (sign 0, magnitude 0); op cleared; display_output=0; complete=0; edge-detect registers cleared. Reset mid-operation, including during COMPUTE, aborts immediately.
- Edge detection: operator_input is acted on only on the cycle it changes from 000 to non-zero. equal_input is acted on only on its rising edge (0 to 1). A held level never re-triggers.
- States: 0 ENTER_A, 1 DIGIT_A, 2 OP_SEL, 3 ENTER_B, 4 DIGIT_B, 5 COMPUTE, 6 DONE.
- ENTER_A:
  - read_input=1 with key ≤9: mag_A = mag_A*10 + key, go to DIGIT_A.
  - If the new value would exceed 32767, the digit is dropped (A unchanged) but the state still moves.
  - Negate edge: toggle sign_A, stay in ENTER_A.
  - Add/sub/mul edge: latch op, go to OP_SEL.
  - equal_input is ignored.
  - The first digit or negate after DONE clears complete.
- DIGIT_A: wait for read_input=0, then return to ENTER_A. Exactly one digit is accepted per strobe.
- OP_SEL: clear B; display_output=0; go to ENTER_B the next cycle.
- ENTER_B / DIGIT_B: same rules as ENTER_A / DIGIT_A, applied to B. An add/sub/mul edge replaces the latched op. An equal rising edge goes to COMPUTE.
- Display during entry: sign-magnitude of the operand being entered. -0 is shown as +0.
- COMPUTE, add/sub:
  - Convert both operands to 17-bit two's complement.
  - Form A+B or A-B in one cycle.
  - Saturate to ±32767.
- COMPUTE, multiply:
  - Sequential shift-add over the 15-bit magnitudes, 15 cycles, 30-bit product.
  - Sign = sign_A XOR sign_B.
  - Magnitude saturates to 32767 if the product exceeds it.
- Zero results always carry sign 0.
- DONE (one cycle):
  - display_output = result in sign-magnitude; complete = 1.
  - Clear A and B; go to ENTER_A.
  - complete and display_output hold until a new digit/negate in ENTER_A or reset.
- Latency from the equal edge to complete=1: add/sub 2 cycles; mul 17 cycles.
- Simultaneous read_input and operator edge in ENTER: the digit wins and the operator edge is discarded.

Test Plan:
- Reset, negate, digits 2,5, add, negate, digits 1,5, equal -> complete=1, display_output=0x8028 (-40).
- Digits 1,0,0,0, add, digits 2,3,4,5, equal -> display_output=3345 (0x0D11), sign 0.
- Negate, digit 3, subtract, negate, digit 5, equal -> +2; then digits 9,9, subtract, equal (B=0) -> +99 and complete cleared on the first new digit.
- Negate, digit 3, multiply, negate, digit 6, equal -> +18 after the multiply latency. Digits 1,2,8 × 2,5,6 -> saturated 0x7FFF.
- Digits 0 × 1,0,0 -> +0 (0x0000, never 0x8000). Negate, 1, add, 1 -> 0x0000.
- Hold equal_input high across DONE into ENTER_A -> no retrigger. Assert nRST during COMPUTE -> state 0, display 0, complete 0. Digits 4,0,0,0,0 -> 4000 (last digit dropped).
